// File: rtl/stage_writeback_if.sv
// Memory-to-writeback stage bus: M-stage slot inputs, pipeline control,
// and the writeback outputs driven back toward the register file.
interface stage_writeback_if #(
  parameter int CNT_W = 32
);
  // Memory-stage slot
  logic             valid_M;
  logic             regwrite_M;
  logic             memtoreg_M;
  logic [2:0]       loadtype_M;
  logic [1:0]       byteoff_M;
  logic [31:0]      aluout_M;
  logic [31:0]      readdata_M;
  logic [4:0]       writereg_M;
  // Pipeline control for the MEM/WB register
  logic             stall_W;
  logic             flush_W;
  // Writeback results
  logic             regwrite_WB;
  logic [31:0]      result_WB;
  logic [4:0]       writereg_WB;
  logic             valid_WB;
  logic             misaligned_WB;
  logic [CNT_W-1:0] retired;

  // Upstream pipeline side: drives the slot and control, observes writeback.
  modport master (
    output valid_M, regwrite_M, memtoreg_M, loadtype_M, byteoff_M,
           aluout_M, readdata_M, writereg_M, stall_W, flush_W,
    input  regwrite_WB, result_WB, writereg_WB, valid_WB, misaligned_WB,
           retired
  );

  // Writeback stage side.
  modport slave (
    input  valid_M, regwrite_M, memtoreg_M, loadtype_M, byteoff_M,
           aluout_M, readdata_M, writereg_M, stall_W, flush_W,
    output regwrite_WB, result_WB, writereg_WB, valid_WB, misaligned_WB,
           retired
  );
endinterface

// File: rtl/stage_writeback.sv
// Writeback stage: one MEM/WB pipeline register with stall/flush control,
// big-endian load extraction, alignment checking and a retirement counter.
// Load extraction and the write-enable qualification are evaluated on the
// M-side inputs and captured, so every WB output comes straight from a flop
// while still appearing exactly one cycle after its M inputs.
module stage_writeback #(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  stage_writeback_if.slave  bus
);

  localparam logic [2:0] LT_LW  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LHU = 3'b010;
  localparam logic [2:0] LT_LB  = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;

  // Big-endian sub-word selection with sign or zero extension.
  // Unlisted load codes fall back to a full-word load.
  function automatic logic [31:0] extract_load(
    input logic [2:0]  ltype,
    input logic [1:0]  off,
    input logic [31:0] word
  );
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] res;
    case (off)
      2'd0:    byte_sel = word[31:24];
      2'd1:    byte_sel = word[23:16];
      2'd2:    byte_sel = word[15:8];
      default: byte_sel = word[7:0];
    endcase
    half_sel = off[1] ? word[15:0] : word[31:16];
    case (ltype)
      LT_LH:   res = {{16{half_sel[15]}}, half_sel};
      LT_LHU:  res = {16'h0000, half_sel};
      LT_LB:   res = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  res = {24'h00_0000, byte_sel};
      default: res = word;
    endcase
    return res;
  endfunction

  // Alignment rule by access size; byte loads can never be misaligned.
  function automatic logic illegal_align(
    input logic [2:0] ltype,
    input logic [1:0] off
  );
    logic bad;
    case (ltype)
      LT_LH, LT_LHU: bad = off[0];
      LT_LB, LT_LBU: bad = 1'b0;
      default:       bad = (off != 2'd0);
    endcase
    return bad;
  endfunction

  // Next-state values for the pipeline register
  logic        misaligned_s;
  logic        regwrite_s;
  logic [31:0] result_s;

  // MEM/WB register contents
  logic             valid_r;
  logic             regwrite_r;
  logic             misaligned_r;
  logic [31:0]      result_r;
  logic [4:0]       writereg_r;
  logic [CNT_W-1:0] retired_r;

  // Qualify the incoming slot: result mux, alignment check, write enable.
  always_comb begin
    misaligned_s = 1'b0;
    regwrite_s   = 1'b0;
    result_s     = 32'h0000_0000;
    misaligned_s = bus.valid_M & bus.memtoreg_M
                 & illegal_align(bus.loadtype_M, bus.byteoff_M);
    if (bus.memtoreg_M) begin
      result_s = extract_load(bus.loadtype_M, bus.byteoff_M, bus.readdata_M);
    end else begin
      result_s = bus.aluout_M;
    end
    // Register zero is hardwired; a misaligned load never writes.
    regwrite_s = bus.valid_M & bus.regwrite_M
               & (bus.writereg_M != 5'd0) & ~misaligned_s;
  end

  // MEM/WB register: flush squashes the slot, stall holds, otherwise load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r      <= 1'b0;
      regwrite_r   <= 1'b0;
      misaligned_r <= 1'b0;
      result_r     <= 32'h0000_0000;
      writereg_r   <= 5'd0;
    end else if (bus.flush_W) begin
      // Squashed slot: its qualifiers must drop with valid.
      valid_r      <= 1'b0;
      regwrite_r   <= 1'b0;
      misaligned_r <= 1'b0;
      result_r     <= result_s;
      writereg_r   <= bus.writereg_M;
    end else if (bus.stall_W) begin
      valid_r      <= valid_r;
      regwrite_r   <= regwrite_r;
      misaligned_r <= misaligned_r;
      result_r     <= result_r;
      writereg_r   <= writereg_r;
    end else begin
      valid_r      <= bus.valid_M;
      regwrite_r   <= regwrite_s;
      misaligned_r <= misaligned_s;
      result_r     <= result_s;
      writereg_r   <= bus.writereg_M;
    end
  end

  // Retirement counter: a live slot counts on the edge that moves it out,
  // so a stalled slot counts once on release and a reset discards it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_r <= {CNT_W{1'b0}};
    end else if (valid_r && !bus.stall_W) begin
      retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      retired_r <= retired_r;
    end
  end

  assign bus.valid_WB      = valid_r;
  assign bus.regwrite_WB   = regwrite_r;
  assign bus.misaligned_WB = misaligned_r;
  assign bus.result_WB     = result_r;
  assign bus.writereg_WB   = writereg_r;
  assign bus.retired       = retired_r;

endmodule

// File: tb/tb_stage_writeback.sv
// Bench for stage_writeback: directed literal checks followed by randomized
// traffic compared every cycle against a slot-level reference model.
module tb_stage_writeback;

  localparam int CNT_W = 4;
  localparam int CNT_MOD = 16;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   chk_en   = 1'b0;

  stage_writeback_if #(.CNT_W(CNT_W)) bus ();

  stage_writeback #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (instruction-slot view) ----------------
  typedef struct {
    bit          valid;
    bit          regwrite;
    bit          memtoreg;
    bit [2:0]    lt;
    bit [1:0]    off;
    bit [31:0]   alu;
    bit [31:0]   rd;
    bit [4:0]    wr;
  } slot_t;

  slot_t m_slot = '{default: 0};
  int    m_ret   = 0;
  bit    m_clean = 1'b1;   // slot is the all-zero reset image

  function automatic bit [31:0] model_result(slot_t s);
    int unsigned bytev, halfv;
    if (!s.memtoreg) return s.alu;
    bytev = (s.rd >> ((3 - int'(s.off)) * 8)) & 32'hFF;
    halfv = (s.rd >> ((s.off >= 2'd2) ? 0 : 16)) & 32'hFFFF;
    case (s.lt)
      3'd1:    return (halfv >= 32768) ? halfv - 32'd65536 : halfv;
      3'd2:    return halfv;
      3'd3:    return (bytev >= 128) ? bytev - 32'd256 : bytev;
      3'd4:    return bytev;
      default: return s.rd;
    endcase
  endfunction

  function automatic bit model_mis(slot_t s);
    bit bad;
    if (s.lt == 3'd1 || s.lt == 3'd2) bad = (s.off % 2) != 0;
    else if (s.lt == 3'd3 || s.lt == 3'd4) bad = 1'b0;
    else bad = (s.off != 2'd0);
    return s.valid && s.memtoreg && bad;
  endfunction

  function automatic bit model_rw(slot_t s);
    return s.valid && s.regwrite && (s.wr != 5'd0) && !model_mis(s);
  endfunction

  // Model update on the same events the pipeline register sees.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_slot  <= '{default: 0};
      m_ret   <= 0;
      m_clean <= 1'b1;
    end else begin
      if (m_slot.valid && !bus.stall_W) m_ret <= (m_ret + 1) % CNT_MOD;
      if (bus.flush_W) begin
        m_slot.valid <= 1'b0;
        m_clean      <= 1'b0;
      end else if (!bus.stall_W) begin
        m_slot <= '{bus.valid_M, bus.regwrite_M, bus.memtoreg_M, bus.loadtype_M,
                    bus.byteoff_M, bus.aluout_M, bus.readdata_M, bus.writereg_M};
        m_clean <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_valid", {31'b0, bus.valid_WB}, {31'b0, m_slot.valid});
      check("cyc_regwrite", {31'b0, bus.regwrite_WB}, {31'b0, model_rw(m_slot)});
      check("cyc_misaligned", {31'b0, bus.misaligned_WB}, {31'b0, model_mis(m_slot)});
      check("cyc_retired", {28'b0, bus.retired}, m_ret);
      if (m_slot.valid || m_clean) begin
        check("cyc_result", bus.result_WB, model_result(m_slot));
        check("cyc_writereg", {27'b0, bus.writereg_WB}, {27'b0, m_slot.wr});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input bit v, input bit rw, input bit m2r, input bit [2:0] lt,
                          input bit [1:0] off, input bit [31:0] alu, input bit [31:0] rd,
                          input bit [4:0] wr);
    bus.valid_M    = v;
    bus.regwrite_M = rw;
    bus.memtoreg_M = m2r;
    bus.loadtype_M = lt;
    bus.byteoff_M  = off;
    bus.aluout_M   = alu;
    bus.readdata_M = rd;
    bus.writereg_M = wr;
  endtask

  task automatic idle();
    set_slot(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0, 5'd0);
  endtask

  initial begin
    reset = 1'b0;
    bus.stall_W = 1'b0;
    bus.flush_W = 1'b0;
    idle();
    step();
    chk_en = 1'b1;
    step();
    // Reset state
    check("rst_valid", {31'b0, bus.valid_WB}, 32'd0);
    check("rst_regwrite", {31'b0, bus.regwrite_WB}, 32'd0);
    check("rst_misaligned", {31'b0, bus.misaligned_WB}, 32'd0);
    check("rst_result", bus.result_WB, 32'd0);
    check("rst_writereg", {27'b0, bus.writereg_WB}, 32'd0);
    check("rst_retired", {28'b0, bus.retired}, 32'd0);
    reset = 1'b1;

    // ALU write, captured on the first edge with reset released
    set_slot(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_1234, 32'h0, 5'd5);
    step();
    check("alu_regwrite", {31'b0, bus.regwrite_WB}, 32'd1);
    check("alu_result", bus.result_WB, 32'h0000_1234);
    check("alu_writereg", {27'b0, bus.writereg_WB}, 32'd5);
    check("alu_ret_before", {28'b0, bus.retired}, 32'd0);
    idle();
    step();
    check("alu_ret_after", {28'b0, bus.retired}, 32'd1);

    // Sub-word loads
    set_slot(1'b1, 1'b1, 1'b1, 3'd3, 2'd1, 32'h0, 32'h1280_5678, 5'd3);
    step();
    check("lb_result", bus.result_WB, 32'hFFFF_FF80);
    set_slot(1'b1, 1'b1, 1'b1, 3'd4, 2'd1, 32'h0, 32'h1280_5678, 5'd3);
    step();
    check("lbu_result", bus.result_WB, 32'h0000_0080);
    set_slot(1'b1, 1'b1, 1'b1, 3'd1, 2'd2, 32'h0, 32'h0000_8001, 5'd3);
    step();
    check("lh_result", bus.result_WB, 32'hFFFF_8001);

    // Misaligned word load
    set_slot(1'b1, 1'b1, 1'b1, 3'd0, 2'd2, 32'h0, 32'hDEAD_BEEF, 5'd7);
    step();
    check("mis_flag", {31'b0, bus.misaligned_WB}, 32'd1);
    check("mis_regwrite", {31'b0, bus.regwrite_WB}, 32'd0);
    check("mis_ret_before", {28'b0, bus.retired}, 32'd4);

    // Register zero is never written; the misaligned load retires here
    set_slot(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_0042, 32'h0, 5'd0);
    step();
    check("mis_ret_after", {28'b0, bus.retired}, 32'd5);
    check("r0_regwrite", {31'b0, bus.regwrite_WB}, 32'd0);
    check("r0_valid", {31'b0, bus.valid_WB}, 32'd1);
    idle();
    step();
    check("r0_retired", {28'b0, bus.retired}, 32'd6);

    // Stall for three cycles, then flush while still stalled
    set_slot(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_ABCD, 32'h0, 5'd9);
    step();
    set_slot(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_5555, 32'h0, 5'd10);
    bus.stall_W = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_result", bus.result_WB, 32'h0000_ABCD);
      check("stall_writereg", {27'b0, bus.writereg_WB}, 32'd9);
      check("stall_valid", {31'b0, bus.valid_WB}, 32'd1);
      check("stall_retired", {28'b0, bus.retired}, 32'd6);
    end
    bus.flush_W = 1'b1;
    step();
    check("flush_valid", {31'b0, bus.valid_WB}, 32'd0);
    check("flush_retired", {28'b0, bus.retired}, 32'd6);
    bus.flush_W = 1'b0;
    bus.stall_W = 1'b0;
    idle();
    step();

    // Counter wrap: 17 retirements from zero on a 4-bit counter
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int i = 0; i < 17; i++) begin
      set_slot(1'b1, 1'b0, 1'b0, 3'd0, 2'd0, i, 32'h0, 5'd1);
      step();
    end
    idle();
    step();
    check("wrap_retired", {28'b0, bus.retired}, 32'd1);
    set_slot(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_0077, 32'h0, 5'd4);
    step();
    // Asynchronous reset in the middle of the cycle
    #2;
    reset = 1'b0;
    #1;
    check("async_retired", {28'b0, bus.retired}, 32'd0);
    check("async_valid", {31'b0, bus.valid_WB}, 32'd0);
    step();
    reset = 1'b1;

    // Randomized traffic checked every cycle by the model
    for (int c = 0; c < 600; c++) begin
      set_slot($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
               2'($urandom_range(0, 3)), $urandom, $urandom,
               ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)));
      bus.stall_W = ($urandom_range(0, 3) == 0);
      bus.flush_W = ($urandom_range(0, 9) == 0);
      if (c == 300) begin
        #2;
        reset = 1'b0;
        #1;
        check("rand_async_retired", {28'b0, bus.retired}, 32'd0);
      end
      if (c == 302) reset = 1'b1;
      step();
    end
    idle();
    bus.stall_W = 1'b0;
    bus.flush_W = 1'b0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_writeback.md
STAGE_WRITEBACK -- requirements
Module: stage_writeback

Interface
REQ-001 Parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous active-low reset; asserted when 0.
REQ-004 valid_M  input  1  memory-stage slot holds a live instruction.
REQ-005 regwrite_M  input  1  instruction writes a register.
REQ-006 memtoreg_M  input  1  1 = result from load data, 0 = from ALU.
REQ-007 loadtype_M  input  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu; other codes behave as lw.
REQ-008 byteoff_M  input  2  data address bits [1:0].
REQ-009 aluout_M  input  32  ALU result.
REQ-010 readdata_M  input  32  raw data-memory word.
REQ-011 writereg_M  input  5  destination register.
REQ-012 stall_W  input  1  hold the MEM/WB register.
REQ-013 flush_W  input  1  squash the incoming slot.
REQ-014 regwrite_WB  output  1  register-file write enable.
REQ-015 result_WB  output  32  register-file write data.
REQ-016 writereg_WB  output  5  register-file write address.
REQ-017 valid_WB  output  1  writeback slot is live.
REQ-018 misaligned_WB  output  1  live load with illegal alignment.
REQ-019 retired  output  CNT_W  count of instructions retired.

Function
REQ-020 The block SHALL hold one MEM/WB pipeline register capturing every M-suffixed input on the rising edge of clk.
- All WB outputs derive from this register.
- Latency from M inputs to WB outputs is exactly one cycle.
REQ-021 Capture rules:
- flush_W=1: valid SHALL load 0, regardless of stall_W; flush has priority.
- flush_W=0, stall_W=1: the register SHALL hold its contents.
- Otherwise the register SHALL load the M inputs.
REQ-022 Byte order is big-endian: offset 0 selects bits [31:24]; offset 3 selects bits [7:0].
- Halfword offset 0 selects bits [31:16]; offset 2 selects bits [15:0].
REQ-023 Load extraction from the registered readdata and byteoff:
- lb and lh SHALL sign-extend the selected field to 32 bits.
- lbu and lhu SHALL zero-extend the selected field to 32 bits.
- lw SHALL pass the word unchanged.
REQ-024 result_WB SHALL equal the extracted load data when memtoreg=1 and the registered aluout otherwise.
REQ-025 misaligned_WB SHALL equal valid & memtoreg & (lw with byteoff!=0, or lh/lhu with byteoff[0]=1).
REQ-026 regwrite_WB SHALL equal valid & regwrite & (writereg!=0) & !misaligned_WB; register 0 is never written.
REQ-027 writereg_WB SHALL present the registered writereg even when regwrite_WB=0.
REQ-028 retired SHALL increment by 1 on each rising edge where valid_WB=1 and stall_W=0.
- Retirement does not depend on regwrite or misalignment.
- The counter wraps from all-ones to 0.
REQ-029 A stalled live slot SHALL be counted exactly once, on the edge that releases it.

Reset
REQ-030 While reset=0, the block SHALL asynchronously clear all register contents and retired, independent of clk.
REQ-031 During and after reset, outputs SHALL be: valid_WB=0, regwrite_WB=0, misaligned_WB=0, result_WB=0, writereg_WB=0, retired=0.
REQ-032 Reset asserted mid-stall SHALL discard the held slot without counting it.
REQ-033 The first capture SHALL occur on the first rising edge with reset=1.

Verification
REQ-034 ALU write:
- Stimulus: valid, regwrite, memtoreg=0, aluout=0x0000_1234, writereg=5.
- Next cycle: regwrite_WB=1, result_WB=0x0000_1234, writereg_WB=5, retired +1.
REQ-035 Signed byte load:
- Stimulus: lb, readdata=0x12_80_56_78, byteoff=1.
- Required: result_WB=0xFFFF_FF80.
- The same stimulus with lbu gives 0x0000_0080; lh with byteoff=2 and readdata=0x0000_8001 gives 0xFFFF_8001.
REQ-036 Misaligned word load:
- Stimulus: lw with byteoff=2, writereg=7.
- Required: misaligned_WB=1, regwrite_WB=0, retired +1.
REQ-037 Register zero:
- Stimulus: regwrite with writereg=0.
- Required: regwrite_WB=0, valid_WB=1.
REQ-038 Stall then flush:
- Stimulus: hold stall_W=1 for 3 cycles, then assert flush_W=1 with stall_W=1.
- During the stall: outputs frozen and retired unchanged.
- After the flush: valid_WB=0.
REQ-039 Wrap and reset:
- Stimulus: CNT_W=4 with 17 consecutive retirements.
- Required: retired=1 at the end.
- Then assert reset=0 asynchronously mid-cycle; retired=0 and valid_WB=0 immediately.
